conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//  Streaming sliding-window generator feeding the convolution stage.
//  - Accepts one IFMAP pixel per handshake in raster order (row 0 col 0 first).
//  - Emits every FILTER_SIZE x FILTER_SIZE window at STRIDE spacing.
//  - Yields OFMAP_SIZE*OFMAP_SIZE windows per frame, in output raster order.
//  - Sits between the input pixel source and the conv MAC array.
// PARAMETERS
//  IP_DATA_WIDTH  7  pixel width in bits, unsigned
//  IFMAP_SIZE     5  input feature map is IFMAP_SIZE x IFMAP_SIZE
//  FILTER_SIZE    3  window edge; range 2..IFMAP_SIZE
//  STRIDE         1  window step in rows and in columns; range >=1
// PORTS
//  clk        in   1                       clock, rising edge
//  rst        in   1                       synchronous, active-high reset
//  in_valid   in   1                       in_data is valid
//  in_ready   out  1                       block accepts in_data this cycle
//  in_data    in   IP_DATA_WIDTH           pixel
//  out_valid  out  1                       win_data is valid
//  out_ready  in   1                       consumer takes the window
//  win_data   out  FILTER_SIZE^2*IP_DATA_WIDTH  window; element (r,c) at [(r*FILTER_SIZE+c)*IP_DATA_WIDTH +: IP_DATA_WIDTH], r=0 top, c=0 left
//  out_row    out  $clog2(OFMAP_SIZE)      OFMAP row index of the window
//  out_col    out  $clog2(OFMAP_SIZE)      OFMAP column index of the window
//  out_last   out  1                       window is the last one of the frame
// BEHAVIOUR
//  - Clock and reset: one clock (clk); rst is synchronous and active-high.
//  - Reset state: out_valid=0, in_ready=1, win_data/out_row/out_col/out_last=0.
//    Row and column counters return to 0.
//    Line-buffer contents are don't-care and are never emitted before being refilled.
//  - Accept: a pixel is accepted when in_valid && in_ready.
//    in_ready = !out_valid || out_ready (single output register, no bubble).
//  - Counters: in_col counts 0..IFMAP_SIZE-1; in_row increments when in_col wraps.
//    After pixel (IFMAP_SIZE-1, IFMAP_SIZE-1) both wrap to 0, so the next accepted pixel starts a new frame.
//  - Storage: FILTER_SIZE-1 row buffers, each IFMAP_SIZE deep, indexed by in_col.
//    On accept, the column tap is {rowbuf[FILTER_SIZE-2][in_col] .. rowbuf[0][in_col], in_data}, oldest row first.
//    Row buffers then cascade: rowbuf[k] <= rowbuf[k-1], and rowbuf[0][in_col] <= in_data.
//    The window register shifts left one column and the tap becomes column FILTER_SIZE-1.
//  - Emit condition, checked on the accepted pixel at (R,C):
//    R >= FILTER_SIZE-1 && C >= FILTER_SIZE-1
//    && (R-FILTER_SIZE+1)%STRIDE==0 && (C-FILTER_SIZE+1)%STRIDE==0.
//  - Latency and outputs: the window is registered; out_valid rises the cycle after the accept.
//    out_row = (R-FILTER_SIZE+1)/STRIDE; out_col = (C-FILTER_SIZE+1)/STRIDE.
//    out_last=1 iff out_row==out_col==OFMAP_SIZE-1.
//    Leftover rows/columns that do not fit an aligned window are consumed and never emitted.
//  - Stall: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
//  - Simultaneous events: out_ready && new emitting accept in the same cycle -> next window replaces the current one, no gap.
//    An accept with no emit and out_ready=1 -> out_valid falls.
//  - Reset mid-frame: any partial frame is discarded and the pending window is dropped (out_valid=0 next cycle).
//  - Arithmetic: pure data movement, no arithmetic on pixels. Divisions and modulos are done by STRIDE-phase counters, not dividers.
// STRUCTURE
//  - Shared yolo params package holds IP_DATA_WIDTH, IFMAP_SIZE, FILTER_SIZE, STRIDE and OFMAP_SIZE.
//  - Add to that package: WIN_ELEMS=FILTER_SIZE*FILTER_SIZE, and typedef pixel_t = logic [IP_DATA_WIDTH-1:0].
//  - Sub-module: conv_line_buffer, a one-row delay memory (IFMAP_SIZE x pixel_t, write-and-read at in_col).
//    Instantiated FILTER_SIZE-1 times.
//  - Counters, window shift register and output register stay in the top module.
// TESTING
//  1. F=3,S=1, pixels 0..24, out_ready=1 -> 9 windows.
//     First window (0,0) = {0,1,2,5,6,7,10,11,12}, one cycle after pixel 12.
//     Last window (2,2) = {12,13,14,17,18,19,22,23,24} with out_last=1.
//  2. F=3,S=2, pixels 0..24 -> 4 windows at (0,0),(0,1),(1,0),(1,1).
//     Window (1,1) = {12,13,14,17,18,19,22,23,24}; no window on pixels 13 or 15.
//  3. Backpressure: hold out_ready=0 for 3 cycles at window (1,1) of case 1.
//     -> win_data stays {6,7,8,11,12,13,16,17,18}, in_ready=0, no pixel lost.
//     Remaining windows match case 1.
//  4. Random in_valid gaps (~50%) plus random out_ready -> window sequence identical to case 1.
//  5. Two back-to-back frames (0..24 then 100..124) -> second-frame first window = {100,101,102,105,106,107,110,111,112}.
//     No window mixes data from both frames.
//  6. Assert rst after pixel 17, then send a full 0..24 frame.
//     -> out_valid=0 the cycle after reset, then exactly 9 windows, as in case 1.

Source files
------------

// File: rtl/conv_window_gen_pkg.sv
// Shared parameters and pixel type for the sliding-window generator.
package conv_window_gen_pkg;

    localparam int IP_DATA_WIDTH = 7;
    localparam int IFMAP_SIZE    = 5;
    localparam int FILTER_SIZE   = 3;
    localparam int STRIDE        = 1;
    localparam int OFMAP_SIZE    = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1;
    localparam int WIN_ELEMS     = FILTER_SIZE * FILTER_SIZE;

    typedef logic [IP_DATA_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One-row pixel delay memory with a registered read port.
module conv_line_buffer
    import conv_window_gen_pkg::*;
#(
    parameter int DEPTH = IFMAP_SIZE,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem_reg [DEPTH];
    pixel_t rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem_reg[rd_addr];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/conv_window_gen.sv
// Streaming FILTER_SIZE x FILTER_SIZE window generator over a raster-order pixel stream.
module conv_window_gen #(
    parameter int  IFMAP_SIZE  = conv_window_gen_pkg::IFMAP_SIZE,
    parameter int  FILTER_SIZE = conv_window_gen_pkg::FILTER_SIZE,
    parameter int  STRIDE      = conv_window_gen_pkg::STRIDE,
    localparam int OFMAP_SIZE  = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1,
    localparam int OW          = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1,
    localparam int DW          = conv_window_gen_pkg::IP_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DW-1:0]                     in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [FILTER_SIZE*FILTER_SIZE*DW-1:0] win_data,
    output logic [OW-1:0]                     out_row,
    output logic [OW-1:0]                     out_col,
    output logic                              out_last
);

    typedef conv_window_gen_pkg::pixel_t pixel_t;

    localparam int CW = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int NB = FILTER_SIZE - 1;
    localparam int WB = FILTER_SIZE * FILTER_SIZE * DW;

    logic [CW-1:0] in_col_reg, in_col_next, in_row_reg, in_row_next;
    logic [PW-1:0] col_phase_reg, col_phase_next, row_phase_reg, row_phase_next;
    logic [OW-1:0] col_idx_reg, col_idx_next, row_idx_reg, row_idx_next;

    logic          out_valid_reg, out_last_reg;
    logic [WB-1:0] win_data_reg;
    logic [OW-1:0] out_row_reg, out_col_reg;

    logic accept, emit, col_ok, row_ok, col_last, row_last;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (in_col_reg == CW'(IFMAP_SIZE - 1));
    assign row_last = (in_row_reg == CW'(IFMAP_SIZE - 1));
    assign col_ok   = (in_col_reg >= CW'(FILTER_SIZE - 1));
    assign row_ok   = (in_row_reg >= CW'(FILTER_SIZE - 1));
    assign emit     = row_ok && col_ok && (row_phase_reg == '0) && (col_phase_reg == '0);

    // Phase counters track (pos-FILTER_SIZE+1) mod STRIDE; idx counters track the quotient.
    always_comb begin
        in_col_next    = in_col_reg;
        in_row_next    = in_row_reg;
        col_phase_next = col_phase_reg;
        row_phase_next = row_phase_reg;
        col_idx_next   = col_idx_reg;
        row_idx_next   = row_idx_reg;
        if (rst) begin
            in_col_next    = '0;
            in_row_next    = '0;
            col_phase_next = '0;
            row_phase_next = '0;
            col_idx_next   = '0;
            row_idx_next   = '0;
        end else if (accept) begin
            if (col_last) begin
                in_col_next    = '0;
                col_phase_next = '0;
                col_idx_next   = '0;
                if (row_last) begin
                    in_row_next    = '0;
                    row_phase_next = '0;
                    row_idx_next   = '0;
                end else begin
                    in_row_next = in_row_reg + 1'b1;
                    if (row_ok) begin
                        if (row_phase_reg == PW'(STRIDE - 1)) begin
                            row_phase_next = '0;
                            row_idx_next   = row_idx_reg + 1'b1;
                        end else begin
                            row_phase_next = row_phase_reg + 1'b1;
                        end
                    end
                end
            end else begin
                in_col_next = in_col_reg + 1'b1;
                if (col_ok) begin
                    if (col_phase_reg == PW'(STRIDE - 1)) begin
                        col_phase_next = '0;
                        col_idx_next   = col_idx_reg + 1'b1;
                    end else begin
                        col_phase_next = col_phase_reg + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        in_col_reg    <= in_col_next;
        in_row_reg    <= in_row_next;
        col_phase_reg <= col_phase_next;
        row_phase_reg <= row_phase_next;
        col_idx_reg   <= col_idx_next;
        row_idx_reg   <= row_idx_next;
    end

    pixel_t lb_rd [NB];
    pixel_t tap   [FILTER_SIZE];

    // Read address looks one step ahead so the registered read lands on the column being accepted.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lb
            pixel_t lb_wr;
            if (gi == 0) begin : g_first
                assign lb_wr = in_data;
            end else begin : g_casc
                assign lb_wr = lb_rd[gi-1];
            end
            conv_line_buffer #(
                .DEPTH (IFMAP_SIZE),
                .AW    (CW)
            ) u_line_buffer (
                .clk     (clk),
                .wr_en   (accept),
                .wr_addr (in_col_reg),
                .wr_data (lb_wr),
                .rd_addr (in_col_next),
                .rd_data (lb_rd[gi])
            );
            assign tap[gi] = lb_rd[NB-1-gi];
        end
    endgenerate

    assign tap[FILTER_SIZE-1] = in_data;

    pixel_t        win_reg  [FILTER_SIZE][FILTER_SIZE];
    pixel_t        win_next [FILTER_SIZE][FILTER_SIZE];
    logic [WB-1:0] win_flat;

    generate
        for (gi = 0; gi < FILTER_SIZE; gi++) begin : g_row
            for (gj = 0; gj < FILTER_SIZE; gj++) begin : g_col
                if (gj == FILTER_SIZE - 1) begin : g_tap
                    assign win_next[gi][gj] = tap[gi];
                end else begin : g_shift
                    assign win_next[gi][gj] = win_reg[gi][gj+1];
                end
                assign win_flat[(gi*FILTER_SIZE+gj)*DW +: DW] = win_next[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (accept) begin
            win_reg <= win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            win_data_reg  <= '0;
            out_row_reg   <= '0;
            out_col_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else if (accept && emit) begin
            out_valid_reg <= 1'b1;
            win_data_reg  <= win_flat;
            out_row_reg   <= row_idx_reg;
            out_col_reg   <= col_idx_reg;
            out_last_reg  <= (row_idx_reg == OW'(OFMAP_SIZE - 1)) && (col_idx_reg == OW'(OFMAP_SIZE - 1));
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign win_data  = win_data_reg;
    assign out_row   = out_row_reg;
    assign out_col   = out_col_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: stride-1 and stride-2 instances on a 5x5 map.
module tb_conv_window_gen;

    localparam int N = 5;
    localparam int F = 3;

    typedef struct {
        logic [62:0] win;
        int          row;
        int          col;
        bit          last;
    } exp_t;

    logic        clk, rst;
    logic        in_valid  [2];
    logic [6:0]  in_data   [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        out_last  [2];
    logic [62:0] win_data  [2];
    logic [1:0]  row0, col0;
    logic [0:0]  row1, col1;

    int   total = 0;
    int   bad   = 0;
    int   pops  [2];
    int   mr    [2];
    int   mc    [2];
    int   img   [2][N][N];
    bit   last_emit [2];
    exp_t q0 [$];
    exp_t q1 [$];

    conv_window_gen #(.IFMAP_SIZE(N), .FILTER_SIZE(F), .STRIDE(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .win_data(win_data[0]), .out_row(row0), .out_col(col0), .out_last(out_last[0])
    );

    conv_window_gen #(.IFMAP_SIZE(N), .FILTER_SIZE(F), .STRIDE(2)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .win_data(win_data[1]), .out_row(row1), .out_col(col1), .out_last(out_last[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [62:0] mkwin(input int base);
        logic [62:0] w;
        w = '0;
        for (int r = 0; r < F; r++)
            for (int c = 0; c < F; c++)
                w[(r*F+c)*7 +: 7] = 7'(base + r*N + c);
        return w;
    endfunction

    // Reference model: keeps the whole frame image and cuts windows out of it directly.
    task automatic model_accept(input int d, input int val);
        int   s, r, c;
        exp_t e;
        s = (d == 0) ? 1 : 2;
        r = mr[d];
        c = mc[d];
        img[d][r][c] = val;
        last_emit[d] = (r >= F-1) && (c >= F-1) && ((r-F+1) % s == 0) && ((c-F+1) % s == 0);
        if (last_emit[d]) begin
            e.win = '0;
            for (int wr = 0; wr < F; wr++)
                for (int wc = 0; wc < F; wc++)
                    e.win[(wr*F+wc)*7 +: 7] = 7'(img[d][r-F+1+wr][c-F+1+wc]);
            e.row  = (r-F+1) / s;
            e.col  = (c-F+1) / s;
            e.last = (e.row == (N-F)/s) && (e.col == (N-F)/s);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (c == N-1) begin
            mc[d] = 0;
            mr[d] = (r == N-1) ? 0 : r + 1;
        end else begin
            mc[d] = c + 1;
        end
    endtask

    task automatic check_pop(input int d);
        exp_t        e;
        logic [31:0] orow, ocol;
        int          qs;
        qs = (d == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
            chk("spurious_window", 64'(out_valid[d]), 64'd0);
        end else begin
            e    = (d == 0) ? q0.pop_front() : q1.pop_front();
            orow = (d == 0) ? 32'(row0) : 32'(row1);
            ocol = (d == 0) ? 32'(col0) : 32'(col1);
            $display("win dut=%0d row=%0d col=%0d last=%0d data=%h", d, orow, ocol, out_last[d], win_data[d]);
            chk("win_data", 64'(win_data[d]), 64'(e.win));
            chk("out_row", 64'(orow), 64'(e.row));
            chk("out_col", 64'(ocol), 64'(e.col));
            chk("out_last", 64'(out_last[d]), 64'(e.last));
            pops[d]++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++)
                if (out_valid[d] && out_ready[d]) check_pop(d);
        end
    end

    task automatic send(input int d, input int val, input bit rnd);
        int budget;
        bit acc;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid[d]  = 1'b0;
                out_ready[d] = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        in_valid[d] = 1'b1;
        in_data[d]  = 7'(val);
        budget = 0;
        acc = 1'b0;
        while (!acc && budget < 200) begin
            out_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = in_ready[d];
            @(posedge clk); #1;
            budget++;
        end
        in_valid[d] = 1'b0;
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
        else model_accept(d, val);
    endtask

    task automatic drain(input int d, input int want);
        int budget, qs;
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        budget = 0;
        qs = (d == 0) ? q0.size() : q1.size();
        while ((qs != 0 || out_valid[d]) && budget < 50) begin
            @(posedge clk); #1;
            qs = (d == 0) ? q0.size() : q1.size();
            budget++;
        end
        chk("queue_empty", 64'(qs), 64'd0);
        chk("window_count", 64'(pops[d]), 64'(want));
        pops[d] = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid[0]), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready[0]), 64'd1);
        chk({tag, "_win_data"}, 64'(win_data[0]), 64'd0);
        chk({tag, "_out_row"}, 64'(row0), 64'd0);
        chk({tag, "_out_col"}, 64'(col0), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last[0]), 64'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b1;
            pops[d]      = 0;
            mr[d]        = 0;
            mc[d]        = 0;
            last_emit[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Stride 1, full-rate stream.
        for (int i = 0; i < 25; i++) begin
            send(0, i, 1'b0);
            chk("s1_valid_after_px", 64'(out_valid[0]), 64'(last_emit[0]));
            if (i == 12) chk("s1_first_window", 64'(win_data[0]), 64'(mkwin(0)));
            if (i == 24) begin
                chk("s1_last_window", 64'(win_data[0]), 64'(mkwin(12)));
                chk("s1_last_flag", 64'(out_last[0]), 64'd1);
            end
        end
        drain(0, 9);

        // Stride 2 skips odd-offset windows.
        for (int i = 0; i < 25; i++) begin
            send(1, i, 1'b0);
            chk("s2_valid_after_px", 64'(out_valid[1]), 64'(last_emit[1]));
            if (i == 24) chk("s2_window_11", 64'(win_data[1]), 64'(mkwin(12)));
        end
        drain(1, 4);

        // Backpressure held on window (1,1) with the next pixel offered.
        for (int i = 0; i < 19; i++) send(0, i, 1'b0);
        in_valid[0]  = 1'b1;
        in_data[0]   = 7'd19;
        out_ready[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_win", 64'(win_data[0]), 64'(mkwin(6)));
            chk("stall_in_ready", 64'(in_ready[0]), 64'd0);
            chk("stall_valid", 64'(out_valid[0]), 64'd1);
            chk("stall_row_col", 64'({row0, col0}), 64'h5);
            @(posedge clk); #1;
        end
        for (int i = 19; i < 25; i++) send(0, i, 1'b0);
        drain(0, 9);

        // Random input gaps and random consumer readiness.
        for (int i = 0; i < 25; i++) send(0, i, 1'b1);
        drain(0, 9);

        // Two frames back to back.
        for (int i = 0; i < 25; i++) send(0, i, 1'b0);
        for (int i = 100; i < 125; i++) begin
            send(0, i, 1'b0);
            if (i == 112) chk("f2_first_window", 64'(win_data[0]), 64'(mkwin(100)));
        end
        drain(0, 18);

        // Reset mid-frame with a window pending.
        for (int i = 0; i < 18; i++) send(0, i, 1'b0);
        out_ready[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("midrst");
        q0.delete();
        mr[0]   = 0;
        mc[0]   = 0;
        pops[0] = 0;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 25; i++) send(0, i, 1'b0);
        drain(0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
